vram_scan_arbiter: RTL and testbench
====================================

Name: vram_scan_arbiter

Overview:
- Shares one single-port synchronous video RAM between two users: display scan-out and a game-logic pixel writer.
- The framebuffer is 160x120 pixels, 8 bits each. Each pixel is shown as a 4x4 block on the 640x480 active area.
- The sync generator's 10-bit X counter (wraps at 767) and 9-bit Y counter feed this block. It schedules RAM reads for display and fits writes into the free slots.
- Its outputs drive the RAM port and the colour path to the DAC.

Parameters:
- DATA_W, 8, pixel/RAM data width
- ADDR_W, 15, RAM address width (19200 words used)
- FB_W, 160, framebuffer columns
- FB_H, 120, framebuffer rows
- H_ACTIVE, 640, visible X count
- V_ACTIVE, 480, visible Y count

Ports:
- clk  in  1  pixel clock, the same clock that drives the sync generator
- rst_n  in  1  asynchronous active-low reset
- counter_x  in  10  current X count from the sync generator
- counter_y  in  9  current Y count from the sync generator
- wr_valid  in  1  writer presents a pixel write
- wr_ready  out  1  block can accept a write
- wr_addr  in  ADDR_W  linear framebuffer address (row*160+col)
- wr_data  in  DATA_W  pixel value to write
- wr_done  out  1  one-cycle pulse: write committed to RAM
- wr_err  out  1  one-cycle pulse: write dropped, address out of range
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0
- pixel_out  out  DATA_W  colour for the DAC, 0 during blanking
- pixel_valid  out  1  pixel_out is an active-area pixel

Behaviour:
- Reset (async assert, sync release):
  - all registered outputs are 0; the hold register is empty, so wr_ready=1.
  - A write pending when reset asserts is discarded with no wr_done.
- active = (counter_x < H_ACTIVE) && (counter_y < V_ACTIVE).
- fetch_slot = active && counter_x[1:0]==0.
- Fetch address = (counter_y>>2)*160 + (counter_x>>2).
  - Implement the multiply as a shift-add: (r<<7)+(r<<5)+c.
  - Maximum address is 19199; compute at 15 bits with no truncation.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready. wr_addr and wr_data are then captured into the 1-deep hold register and wr_ready=0.
  - Accepted wr_addr >= FB_W*FB_H: no capture, wr_err pulses next cycle, wr_ready stays 1.
- FSM state S_IDLE (hold empty):
  - accepting an in-range write -> S_HOLD.
- FSM state S_HOLD (hold valid), evaluated every cycle:
  - fetch_slot -> stay in S_HOLD. The fetch takes the RAM and the write stalls.
  - no fetch_slot -> issue the write: mem_en=1, mem_we=1, hold addr/data on the RAM port, wr_done=1, all in the same registered cycle. Next state is S_IDLE.
  - wr_ready returns to 1 the cycle after the write is issued; there is no bypass. Peak write throughput is 1 per 2 clocks.
- RAM port on a fetch_slot: mem_en=1, mem_we=0, mem_addr=fetch address (registered).
- With no fetch and no write, mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
- Display pipeline:
  - Fetch issued at edge e. mem_rdata is sampled at edge e+2 into pixel_out, which then holds for 4 clocks.
  - pixel_valid is active delayed by the same 3-cycle pipeline.
  - When the delayed active is 0, pixel_out=0.
  - pixel_out and pixel_valid therefore lag counter_x/counter_y by 3 clocks; the top level delays its syncs to match.
- Write slots available:
  - 3 of every 4 clocks in the active area.
  - every clock for counter_x 640..767.
  - every clock on lines counter_y >= 480.
- The writer cannot starve: the longest wait in S_HOLD is 1 cycle.
- Counter wrap (X 767->0, Y 511->0) needs no special handling; all decisions are combinational on the current counters.

Optional Feature:
- Macro: VRAM_VBLANK_WRITE_ONLY_EN.
- Defined: S_HOLD issues a write only when counter_y >= V_ACTIVE, giving tear-free updates. A write accepted during active lines waits up to one full frame. Handshake is otherwise unchanged.
- Undefined: writes issue in any non-fetch slot, as described in Behaviour.

Test Plan:
- Reset: assert rst_n=0 mid-line with a write pending -> all outputs 0, wr_ready=1, no wr_done after release, RAM untouched at that address.
- Scan-out: preload RAM[0]=0x11, RAM[1]=0x22, RAM[160]=0x33.
  - At counter_y=0, counter_x=0: pixel_out=0x11 for 4 clocks starting 3 clocks later, then 0x22.
  - At counter_y=4: the first pixel is 0x33.
  - At counter_x>=640: pixel_valid=0 and pixel_out=0.
- Write during active area: wr_valid at counter_x=3 (the next cycle is x=4, a fetch slot), addr=500, data=0xAB.
  - The write stalls 1 cycle and is issued at the x=5 slot, with mem_we=1 and wr_done in the same cycle; wr_ready=1 the cycle after.
  - A later read of RAM[500] returns 0xAB.
- Back-to-back: wr_valid held high for 20 clocks with counter_y=490 -> 10 writes and 10 wr_done pulses, with wr_ready alternating 1/0.
- Out of range: wr_addr=19200 -> wr_err pulses once, wr_done stays 0, mem_we stays 0, wr_ready stays 1.
- VRAM_VBLANK_WRITE_ONLY_EN defined: write accepted at counter_y=100 -> no mem_we until counter_y=480, then the write is issued with wr_done in the same cycle.

Source files
------------

// File: rtl/vram_scan_arbiter.sv
// Shares one single-port synchronous VRAM between display scan-out and a pixel writer.
// Optional VRAM_VBLANK_WRITE_ONLY_EN: held writes are issued only on lines at or below V_ACTIVE.
module vram_scan_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        counter_x,
  input  logic [8:0]        counter_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t            stateReg, stateNext;
  logic [ADDR_W-1:0] holdAddrReg;
  logic [DATA_W-1:0] holdDataReg;
  logic              wrDoneReg, wrErrReg;
  logic              memEnReg, memWeReg;
  logic [ADDR_W-1:0] memAddrReg;
  logic [DATA_W-1:0] memWdataReg;
  logic              fetchD1Reg, fetchD2Reg;
  logic              activeD1Reg, activeD2Reg;
  logic              pixelValidReg;
  logic [DATA_W-1:0] pixelOutReg;

  logic              active, fetchSlot;
  logic [6:0]        fbRow;
  logic [7:0]        fbCol;
  logic [ADDR_W-1:0] fetchAddr;
  logic              wrAccept, wrInRange, issueOk;
  logic              capture, issueWrite;

  assign active    = (counter_x < 10'(H_ACTIVE)) && (counter_y < 9'(V_ACTIVE));
  assign fetchSlot = active && (counter_x[1:0] == 2'b00);

  // row*160 as (row<<7)+(row<<5); 15 bits covers the top address 19199
  assign fbRow     = counter_y[8:2];
  assign fbCol     = counter_x[9:2];
  assign fetchAddr = ADDR_W'({fbRow, 7'b0}) + ADDR_W'({fbRow, 5'b0}) + ADDR_W'(fbCol);

  assign wr_ready  = (stateReg == S_IDLE);
  assign wrAccept  = wr_valid && wr_ready;
  assign wrInRange = wr_addr < ADDR_W'(FB_W * FB_H);

`ifdef VRAM_VBLANK_WRITE_ONLY_EN
  assign issueOk = !fetchSlot && (counter_y >= 9'(V_ACTIVE));
`else
  assign issueOk = !fetchSlot;
`endif

  always_comb begin
    stateNext  = stateReg;
    capture    = 1'b0;
    issueWrite = 1'b0;
    case (stateReg)
      S_IDLE: begin
        if (wrAccept && wrInRange) begin
          capture   = 1'b1;
          stateNext = S_HOLD;
        end
      end
      S_HOLD: begin
        if (issueOk) begin
          issueWrite = 1'b1;
          stateNext  = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= S_IDLE;
      holdAddrReg <= '0;
      holdDataReg <= '0;
      wrDoneReg   <= 1'b0;
      wrErrReg    <= 1'b0;
      memEnReg    <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
    end else begin
      stateReg  <= stateNext;
      wrDoneReg <= issueWrite;
      wrErrReg  <= wrAccept && !wrInRange;
      if (capture) begin
        holdAddrReg <= wr_addr;
        holdDataReg <= wr_data;
      end
      // Fetch and write issue are mutually exclusive; the fetch always owns its slot
      if (fetchSlot) begin
        memEnReg   <= 1'b1;
        memWeReg   <= 1'b0;
        memAddrReg <= fetchAddr;
      end else if (issueWrite) begin
        memEnReg    <= 1'b1;
        memWeReg    <= 1'b1;
        memAddrReg  <= holdAddrReg;
        memWdataReg <= holdDataReg;
      end else begin
        memEnReg <= 1'b0;
        memWeReg <= 1'b0;
      end
    end
  end

  // RAM returns data one clock after the fetch; it is captured on the second edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchD1Reg    <= 1'b0;
      fetchD2Reg    <= 1'b0;
      activeD1Reg   <= 1'b0;
      activeD2Reg   <= 1'b0;
      pixelValidReg <= 1'b0;
      pixelOutReg   <= '0;
    end else begin
      fetchD1Reg    <= fetchSlot;
      fetchD2Reg    <= fetchD1Reg;
      activeD1Reg   <= active;
      activeD2Reg   <= activeD1Reg;
      pixelValidReg <= activeD2Reg;
      if (!activeD2Reg) begin
        pixelOutReg <= '0;
      end else if (fetchD2Reg) begin
        pixelOutReg <= mem_rdata;
      end
    end
  end

  assign wr_done     = wrDoneReg;
  assign wr_err      = wrErrReg;
  assign mem_en      = memEnReg;
  assign mem_we      = memWeReg;
  assign mem_addr    = memAddrReg;
  assign mem_wdata   = memWdataReg;
  assign pixel_out   = pixelOutReg;
  assign pixel_valid = pixelValidReg;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter: bench-side RAM, pixel and write scoreboards.
module tb_vram_scan_arbiter;

  logic        clk;
  logic        rst_n;
  logic [9:0]  counter_x;
  logic [8:0]  counter_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        wr_err;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pixel_out;
  logic        pixel_valid;

  vram_scan_arbiter dut (
    .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_err(wr_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input int a);
    case (a)
      0:       return 8'h11;
      1:       return 8'h22;
      160:     return 8'h33;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction

  // Single-port synchronous RAM with preloaded contents
  logic [7:0] ramMem     [0:32767];
  logic       ramWritten [0:32767];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ramMem[mem_addr]     <= mem_wdata;
        ramWritten[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= (ramWritten[mem_addr] === 1'b1) ? ramMem[mem_addr] : initVal(int'(mem_addr));
      end
    end
  end

  typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic v; logic [7:0] p; } pix_t;

  wr_t        wrQ[$];
  pix_t       pixQ[$];
  logic [7:0] shadow[int];
  int         checks = 0;
  int         failures = 0;
  int         doneCount = 0;
  int         accCount = 0;
  logic       expErr = 1'b0;

  function automatic logic [7:0] modelAt(input int a);
    return shadow.exists(a) ? shadow[a] : initVal(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_ctl"}, 32'({wr_done, wr_err, mem_en, mem_we, pixel_valid}), 32'd0);
    chk({tag, "_data"}, 32'({mem_addr, mem_wdata, pixel_out}), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
  endtask

  // Called once per cycle after the edge: pops the write and pixel scoreboards
  task automatic monitor();
    wr_t  w;
    pix_t e;
    if (mem_en && mem_we) begin
      chk("write_expected", 32'(wrQ.size() != 0), 32'd1);
      chk("wr_done_with_write", 32'(wr_done), 32'd1);
      if (wrQ.size() != 0) begin
        w = wrQ.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(w.a));
        chk("write_data", 32'(mem_wdata), 32'(w.d));
        shadow[int'(w.a)] = w.d;
      end
    end else if (wr_done) begin
      chk("wr_done_without_write", 32'(mem_we), 32'd1);
    end
    if (wr_done) doneCount++;
    chk("wr_err", 32'(wr_err), 32'(expErr));
    if (pixQ.size() >= 3) begin
      e = pixQ.pop_front();
      chk("pixel_valid", 32'(pixel_valid), 32'(e.v));
      chk("pixel_out", 32'(pixel_out), 32'(e.p));
    end
  endtask

  task automatic tick(input int x, input int y);
    pix_t e;
    bit   act;
    counter_x = 10'(x);
    counter_y = 9'(y);
    act = (x < 640) && (y < 480);
    e.v = act;
    e.p = act ? modelAt((y / 4) * 160 + (x / 4)) : 8'h00;
    pixQ.push_back(e);
    expErr = 1'b0;
    if (wr_valid && wr_ready) begin
      accCount++;
      if (wr_addr < 15'd19200) wrQ.push_back('{a: wr_addr, d: wr_data});
      else expErr = 1'b1;
    end
    @(posedge clk);
    #1;
    monitor();
  endtask

  initial begin
    counter_x = '0;
    counter_y = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkReset("reset");
    rst_n = 1'b1;

    // Scan-out: first line, right edge into blanking, then second framebuffer row
    for (int x = 0; x < 12; x++) tick(x, 0);
    for (int x = 636; x < 648; x++) tick(x, 0);
    for (int x = 0; x < 8; x++) tick(x, 4);

`ifndef VRAM_VBLANK_WRITE_ONLY_EN
    // Write offered just before a fetch slot: stalls one cycle, issues at x=5
    wr_addr = 15'd500;
    wr_data = 8'hAB;
    for (int x = 0; x < 8; x++) begin
      wr_valid = (x == 3);
      tick(x, 10);
      if (x == 3) begin
        chk("stall_ready_low", 32'(wr_ready), 32'd0);
        chk("stall_no_we_x3", 32'(mem_we), 32'd0);
      end
      if (x == 4) begin
        chk("stall_fetch_en", 32'(mem_en), 32'd1);
        chk("stall_fetch_we", 32'(mem_we), 32'd0);
        chk("stall_no_done", 32'(wr_done), 32'd0);
      end
      if (x == 5) begin
        chk("issue_we", 32'(mem_we), 32'd1);
        chk("issue_done", 32'(wr_done), 32'd1);
        chk("issue_addr", 32'(mem_addr), 32'd500);
        chk("issue_ready_back", 32'(wr_ready), 32'd1);
      end
    end
`else
    // Write accepted on an active line waits for vertical blanking
    wr_addr = 15'd500;
    wr_data = 8'hAB;
    for (int x = 0; x < 8; x++) begin
      wr_valid = (x == 3);
      tick(x, 100);
      if (x >= 3) chk("vb_hold_no_we", 32'(mem_we), 32'd0);
    end
    for (int x = 0; x < 8; x++) begin
      tick(x, 479);
      chk("vb_line479_no_we", 32'(mem_we), 32'd0);
    end
    tick(0, 480);
    chk("vb_issue_we", 32'(mem_we), 32'd1);
    chk("vb_issue_done", 32'(wr_done), 32'd1);
    for (int x = 1; x < 4; x++) tick(x, 480);
`endif
    wr_valid = 1'b0;
    // RAM[500] shown at row 3, column 20
    for (int x = 80; x < 88; x++) tick(x, 12);

    // Back-to-back writes in vertical blanking: one accept every two clocks
    doneCount = 0;
    accCount  = 0;
    wr_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_addr = 15'(1000 + k);
      wr_data = 8'(8'hC0 + k);
      chk("b2b_ready", 32'(wr_ready), 32'((k % 2) == 0));
      tick(k, 490);
    end
    wr_valid = 1'b0;
    chk("b2b_accepts", 32'(accCount), 32'd10);
    chk("b2b_done_pulses", 32'(doneCount), 32'd10);
    for (int x = 160; x < 240; x++) tick(x, 24);

    // Out-of-range address, then the highest legal address
    doneCount = 0;
    wr_valid  = 1'b1;
    wr_addr   = 15'd19200;
    wr_data   = 8'h5A;
    tick(0, 490);
    chk("oor_err", 32'(wr_err), 32'd1);
    chk("oor_ready", 32'(wr_ready), 32'd1);
    chk("oor_no_we", 32'(mem_we), 32'd0);
    chk("oor_no_done", 32'(wr_done), 32'd0);
    wr_valid = 1'b0;
    tick(1, 490);
    chk("oor_err_once", 32'(wr_err), 32'd0);
    chk("oor_done_count", 32'(doneCount), 32'd0);
    wr_valid = 1'b1;
    wr_addr  = 15'd19199;
    wr_data  = 8'h77;
    tick(2, 490);
    wr_valid = 1'b0;
    tick(3, 490);
    chk("max_addr_done", 32'(wr_done), 32'd1);
    for (int x = 636; x < 644; x++) begin
      tick(x, 476);
      if (x == 636) chk("max_fetch_addr", 32'(mem_addr), 32'd19199);
    end

    // Reset mid-line with a write pending in the hold register
    wr_addr = 15'd640;
    wr_data = 8'hEE;
    for (int x = 0; x < 5; x++) begin
      wr_valid = (x == 3);
      tick(x, 20);
    end
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chkReset("midreset");
    wrQ.delete();
    pixQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    doneCount = 0;
    for (int x = 0; x < 8; x++) tick(x, 490);
    chk("reset_discard_no_done", 32'(doneCount), 32'd0);
    for (int x = 0; x < 8; x++) tick(x, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
